// File: rtl/memory_stage_if.sv
// Data-memory bus between memory_stage (master) and the data memory (slave).
// Single outstanding request: mem_req is held until mem_ack.
// Also holds the shared one-hot opcode bit positions, guarded so other files can
// repeat them.

`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 11
`endif
`ifndef RTYPE
`define RTYPE 0
`endif
`ifndef LOAD
`define LOAD 2
`endif
`ifndef STORE
`define STORE 3
`endif

interface memory_stage_if #(
    parameter int DWIDTH = 32
) ();
    logic                  mem_req;
    logic                  mem_we;
    logic [DWIDTH-1:0]     mem_addr;
    logic [DWIDTH-1:0]     mem_wdata;
    logic [DWIDTH/8-1:0]   mem_sel;
    logic                  mem_ack;
    logic [DWIDTH-1:0]     mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_sel,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_sel,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/memory_stage.sv
// Memory pipeline stage: passes non-memory results through with one cycle of
// latency and runs a single-outstanding LOAD/STORE transaction on the data bus.
// Optional build macro MISALIGN_TRAP_EN: misaligned half/word accesses are
// reported on me_o_misaligned instead of being force-aligned.
//
// state | meaning
// IDLE  | no access in flight, accepting from execute
// WAIT  | bus request outstanding, waiting for ack
// HOLD  | ack seen while writeback stalled, result parked in hold register

`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 11
`endif
`ifndef LOAD
`define LOAD 2
`endif
`ifndef STORE
`define STORE 3
`endif

module memory_stage #(
    parameter int AWIDTH      = 5,
    parameter int DWIDTH      = 32,
    parameter int FUNCT_WIDTH = 3,
    parameter int PC_WIDTH    = 32
) (
    input  logic                     me_clk,
    input  logic                     me_rst,
    input  logic                     me_i_ce,
    input  logic [`OPCODE_WIDTH-1:0] me_i_opcode,
    input  logic [FUNCT_WIDTH-1:0]   me_i_funct3,
    input  logic [DWIDTH-1:0]        me_i_alu_value,
    input  logic [DWIDTH-1:0]        me_i_data_rs2,
    input  logic [DWIDTH-1:0]        me_i_data_rd,
    input  logic [AWIDTH-1:0]        me_i_addr_rd,
    input  logic                     me_i_we_reg,
    input  logic [PC_WIDTH-1:0]      me_i_pc,
    input  logic                     me_i_stall,
    input  logic                     me_i_flush,
    output logic                     me_o_stall,
    output logic                     me_o_flush,
    memory_stage_if.master           me_mem,
    output logic                     me_o_ce,
    output logic [AWIDTH-1:0]        me_o_addr_rd,
    output logic [DWIDTH-1:0]        me_o_data_rd,
    output logic                     me_o_we_reg,
    output logic [PC_WIDTH-1:0]      me_o_pc,
    output logic                     me_o_misaligned
);

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    state_t                 state_q, state_d;
    logic                   req_q, mem_we_q;
    logic [DWIDTH-1:0]      addr_q, wdata_q, hold_q;
    logic [DWIDTH/8-1:0]    sel_q;
    logic [FUNCT_WIDTH-1:0] funct3_q;
    logic [1:0]             lane_q;
    logic [AWIDTH-1:0]      rd_q;
    logic                   wreg_q, kill_q, mis_q;
    logic [PC_WIDTH-1:0]    pc_q;

    logic                   mem_op, trap, dlv, kill_eff;
    logic [DWIDTH/8-1:0]    sel_new;
    logic [DWIDTH-1:0]      wdata_new, load_val, dlv_data;
    logic [7:0]             byte_v;
    logic [15:0]            half_v;
    logic                   unused_bits;

    assign unused_bits = ^me_i_opcode;

    assign mem_op   = me_i_ce & (me_i_opcode[`LOAD] | me_i_opcode[`STORE]);
    assign kill_eff = kill_q | me_i_flush;

    assign me_o_stall = (state_q != IDLE) | me_i_stall;
    assign me_o_flush = me_i_flush;

    assign me_mem.mem_req   = req_q;
    assign me_mem.mem_we    = mem_we_q;
    assign me_mem.mem_addr  = addr_q;
    assign me_mem.mem_wdata = wdata_q;
    assign me_mem.mem_sel   = sel_q;
    assign me_o_misaligned  = mis_q;

    // Byte-lane enables and lane-replicated store data from access size and address
    always_comb begin
        sel_new   = '0;
        wdata_new = me_i_data_rs2;
        case (me_i_funct3[1:0])
            2'b00: begin
                sel_new   = 4'b0001 << me_i_alu_value[1:0];
                wdata_new = {4{me_i_data_rs2[7:0]}};
            end
            2'b01: begin
                sel_new   = me_i_alu_value[1] ? 4'b1100 : 4'b0011;
                wdata_new = {2{me_i_data_rs2[15:0]}};
            end
            2'b10:   sel_new = 4'b1111;
            default: sel_new = '0;
        endcase
    end

    // Misaligned half/word detection, only when trapping is built in
    always_comb begin
`ifdef MISALIGN_TRAP_EN
        trap = ((me_i_funct3[1:0] == 2'b01) & me_i_alu_value[0]) |
               ((me_i_funct3[1:0] == 2'b10) & (me_i_alu_value[1:0] != 2'b00));
`else
        trap = 1'b0;
`endif
    end

    // Load extract and extend from the read word using the latched size and lane
    always_comb begin
        byte_v   = 8'h00;
        half_v   = me_mem.mem_rdata[15:0];
        load_val = '0;
        case (lane_q)
            2'd0: byte_v = me_mem.mem_rdata[7:0];
            2'd1: byte_v = me_mem.mem_rdata[15:8];
            2'd2: byte_v = me_mem.mem_rdata[23:16];
            default: byte_v = me_mem.mem_rdata[31:24];
        endcase
        if (lane_q[1]) half_v = me_mem.mem_rdata[31:16];
        case (funct3_q)
            3'b000:  load_val = {{24{byte_v[7]}}, byte_v};
            3'b001:  load_val = {{16{half_v[15]}}, half_v};
            3'b010:  load_val = me_mem.mem_rdata;
            3'b100:  load_val = {24'h0, byte_v};
            3'b101:  load_val = {16'h0, half_v};
            default: load_val = '0;
        endcase
    end

    // Delivery edge detection; stores hand back zero data
    always_comb begin
        dlv      = ((state_q == WAIT) & me_mem.mem_ack & ~me_i_stall) |
                   ((state_q == HOLD) & ~me_i_stall);
        dlv_data = (state_q == HOLD) ? hold_q : (mem_we_q ? '0 : load_val);
    end

    // State register
    always_ff @(posedge me_clk or posedge me_rst) begin
        if (me_rst) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (!me_i_stall && !me_i_flush && mem_op && !trap) state_d = WAIT;
            WAIT: if (me_mem.mem_ack) state_d = me_i_stall ? HOLD : IDLE;
            HOLD: if (!me_i_stall) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus, latch and writeback output registers
    always_ff @(posedge me_clk or posedge me_rst) begin
        if (me_rst) begin
            req_q <= 1'b0;  mem_we_q <= 1'b0;  addr_q <= '0;  wdata_q <= '0;
            sel_q <= '0;    funct3_q <= '0;    lane_q <= '0;  rd_q <= '0;
            wreg_q <= 1'b0; pc_q <= '0;        kill_q <= 1'b0; hold_q <= '0;
            mis_q <= 1'b0;  me_o_ce <= 1'b0;   me_o_addr_rd <= '0;
            me_o_data_rd <= '0; me_o_we_reg <= 1'b0; me_o_pc <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (me_i_stall) begin
                        // writeback stalled: hold everything
                    end else if (me_i_flush) begin
                        me_o_ce     <= 1'b0;
                        me_o_we_reg <= 1'b0;
                        mis_q       <= 1'b0;
                    end else if (mem_op && trap) begin
                        me_o_ce      <= 1'b1;
                        me_o_we_reg  <= 1'b0;
                        mis_q        <= 1'b1;
                        me_o_addr_rd <= me_i_addr_rd;
                        me_o_pc      <= me_i_pc;
                    end else if (mem_op) begin
                        req_q    <= 1'b1;
                        mem_we_q <= me_i_opcode[`STORE];
                        addr_q   <= {me_i_alu_value[DWIDTH-1:2], 2'b00};
                        wdata_q  <= wdata_new;
                        sel_q    <= sel_new;
                        funct3_q <= me_i_funct3;
                        lane_q   <= me_i_alu_value[1:0];
                        rd_q     <= me_i_addr_rd;
                        wreg_q   <= me_i_we_reg;
                        pc_q     <= me_i_pc;
                        me_o_ce  <= 1'b0;
                        mis_q    <= 1'b0;
                    end else if (me_i_ce) begin
                        me_o_ce      <= 1'b1;
                        me_o_data_rd <= me_i_data_rd;
                        me_o_addr_rd <= me_i_addr_rd;
                        me_o_we_reg  <= me_i_we_reg;
                        me_o_pc      <= me_i_pc;
                        mis_q        <= 1'b0;
                    end else begin
                        me_o_ce <= 1'b0;
                        mis_q   <= 1'b0;
                    end
                end
                WAIT: begin
                    if (me_i_flush) kill_q <= 1'b1;
                    if (me_mem.mem_ack) begin
                        req_q <= 1'b0;
                        if (me_i_stall) hold_q <= dlv_data;
                    end
                end
                HOLD: if (me_i_flush) kill_q <= 1'b1;
                default: ;
            endcase
            if (dlv) begin
                kill_q       <= 1'b0;
                mis_q        <= 1'b0;
                me_o_ce      <= ~kill_eff;
                me_o_we_reg  <= ~kill_eff & wreg_q & ~mem_we_q;
                me_o_data_rd <= dlv_data;
                me_o_addr_rd <= rd_q;
                me_o_pc      <= pc_q;
            end
        end
    end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
Pipeline stage directly downstream of the execute stage. It consumes the ALU result, store data, funct3, one-hot opcode and destination info. For LOAD/STORE it runs a single-outstanding request/ack transaction on the data-memory bus, including byte-lane select and load extract/extend. It hands a registered result to writeback and stalls execute while a memory access is in flight.

Parameters:
AWIDTH, 5, register address width
DWIDTH, 32, data/address width (fixed 32; byte lanes = DWIDTH/8)
FUNCT_WIDTH, 3, funct3 width
PC_WIDTH, 32, PC width (pc passed through)

Ports:
me_clk  in  1  clock, rising edge
me_rst  in  1  reset, asynchronous, active-high
me_i_ce  in  1  valid instruction from execute
me_i_opcode  in  `OPCODE_WIDTH  one-hot opcode (`LOAD, `STORE used)
me_i_funct3  in  FUNCT_WIDTH  access size/sign
me_i_alu_value  in  DWIDTH  effective address
me_i_data_rs2  in  DWIDTH  store data
me_i_data_rd  in  DWIDTH  result for non-memory ops
me_i_addr_rd  in  AWIDTH  destination register
me_i_we_reg  in  1  register write enable
me_i_pc  in  PC_WIDTH  instruction PC
me_i_stall  in  1  stall from writeback
me_i_flush  in  1  kill current/in-flight instruction
me_o_stall  out  1  stall to execute
me_o_flush  out  1  flush forwarded upstream
me_o_mem_req  out  1  bus request, held until ack
me_o_mem_we  out  1  1 = store
me_o_mem_addr  out  DWIDTH  word-aligned address
me_o_mem_wdata  out  DWIDTH  lane-replicated store data
me_o_mem_sel  out  DWIDTH/8  byte-lane enables
me_i_mem_ack  in  1  transaction complete
me_i_mem_rdata  in  DWIDTH  read word
me_o_ce  out  1  valid result to writeback
me_o_addr_rd  out  AWIDTH  destination register
me_o_data_rd  out  DWIDTH  result/load data
me_o_we_reg  out  1  write enable to writeback
me_o_pc  out  PC_WIDTH  instruction PC
me_o_misaligned  out  1  misaligned-access flag

Behaviour:
- Reset: all outputs 0; state IDLE; kill flag 0. Reset mid-transaction drops me_o_mem_req immediately; the bus tolerates abandoned cycles.
- States: IDLE, WAIT (request outstanding), HOLD (ack received while me_i_stall=1).
- me_o_stall = (state != IDLE) | me_i_stall. Registered source only; no ack->stall path.
- me_o_flush = me_i_flush (combinational).
- IDLE, me_i_stall=1: all output registers hold.
- IDLE, me_i_flush=1: me_o_ce<=0, me_o_we_reg<=0, nothing accepted.
- IDLE, me_i_ce=1, non-memory op: next edge me_o_ce<=1 and data_rd/addr_rd/we_reg/pc are copied. Latency 1.
- IDLE, me_i_ce=0: me_o_ce<=0.
- IDLE, LOAD/STORE:
  - Next edge: req<=1; addr={alu_value[31:2],2'b00}; latch funct3, addr[1:0], rd, we_reg, pc; me_o_ce<=0; state->WAIT.
  - Store sel: SB = 1<<a[1:0], wdata = byte x4; SH = a[1]?1100:0011, wdata = half x2; SW = 1111.
  - Load sel uses the same pattern by size; mem_we=0.
- WAIT, ack=0: bus outputs stable.
- WAIT, ack=1: req<=0.
  - If me_i_stall=0: result delivered next edge, state->IDLE.
  - If me_i_stall=1: result latched into hold register, state->HOLD.
- Load extract by funct3: 000 LB sign-extend lane a[1:0]; 001 LH sign-extend lane a[1]; 010 LW; 100 LBU, 101 LHU zero-extend. Other codes give 0.
- Store completion: me_o_ce=1, me_o_we_reg=0.
- HOLD: on the first edge with me_i_stall=0, deliver the held result; state->IDLE.
- Flush in WAIT/HOLD: set kill flag. The bus transaction still completes (no abort). The delivered result has me_o_ce=0, we_reg=0. The kill flag clears on return to IDLE.
- Outputs other than me_o_ce change only on delivery edges.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: halfword with a[0]=1, or word with a[1:0]!=0, issues no bus request. Next edge: me_o_ce=1, me_o_we_reg=0, me_o_misaligned=1 for one cycle; state stays IDLE.
- Undefined: low address bits beyond lane select are ignored, access proceeds with forced alignment, me_o_misaligned tied 0.

Test Plan:
- RTYPE passthrough: ce=1, data_rd=0x1E, rd=3, we=1 -> next cycle me_o_ce=1, data_rd=0x1E, addr_rd=3, we_reg=1; me_o_mem_req never high.
- LB: alu_value=0x1003, ack 3 cycles after req, rdata=0x80000000 -> mem_addr=0x1000, sel=1000, we=0; me_o_stall high from issue until return to IDLE; result data_rd=0xFFFFFF80, we_reg=1.
- SH: alu_value=0x2002, rs2=0x0000BEEF -> sel=1100, wdata=0xBEEFBEEF, mem_we=1; after ack me_o_ce=1, we_reg=0.
- LHU at 0x3001:
  - MISALIGN_TRAP_EN defined -> no req, me_o_misaligned=1, we_reg=0.
  - Undefined -> addr=0x3000, sel=0011, rdata=0x0000ABCD gives 0x0000ABCD.
- LW, ack while me_i_stall=1 (rdata=0xDEADBEEF) -> state HOLD, outputs unchanged; two cycles later stall released -> data_rd=0xDEADBEEF, me_o_ce=1.
- Flush during WAIT, then ack -> result discarded (ce=0, we_reg=0). Separately, me_rst asserted in WAIT -> req/stall/ce fall immediately without a clock edge.
